// File: rtl/dtfag_seq_ctrl.sv
// Sequencing controller for the DTFAG twiddle path of a 65536-point radix-16
// FFT/IFFT. Walks stage-major / group-ascending through STG_NUM stages of
// 2^GRP_W groups, one group per non-stalled cycle, and tells the DTFAG
// multiplier mux which operand to use for each issued group.
module dtfag_seq_ctrl #(
  parameter int STG_NUM = 4,
  parameter int GRP_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ifft_mode,
  input  logic             hold,
  output logic [1:0]       Mul_sel,
  output logic [1:0]       stage_idx,
  output logic [GRP_W-1:0] grp_idx,
  output logic             tw_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] LAST_STG = 2'(STG_NUM - 1);

  state_t           state;
  logic [1:0]       stg_cnt;
  logic [GRP_W-1:0] grp_cnt;
  logic             mode_lat;
  logic             last_grp;

  assign last_grp = &grp_cnt;

  // Stages before the last use the twiddle product; the last stage either
  // bypasses (FFT) or applies the N^-1 scale factor (IFFT).
  function automatic logic [1:0] mul_sel_of(input logic [1:0] stg, input logic mode);
    if (stg == LAST_STG) begin
      return mode ? 2'd2 : 2'd0;
    end
    return 2'd1;
  endfunction

  // Sequencer FSM; every output is a register updated on the issuing edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      stg_cnt   <= 2'd0;
      grp_cnt   <= '0;
      mode_lat  <= 1'b0;
      Mul_sel   <= 2'd0;
      stage_idx <= 2'd0;
      grp_idx   <= '0;
      tw_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      tw_valid <= 1'b0;
      Mul_sel  <= 2'd0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          // busy is still high during the done cycle, so a start arriving
          // then is ignored rather than restarting immediately.
          if (start && !busy) begin
            state    <= RUN;
            mode_lat <= ifft_mode;
            stg_cnt  <= 2'd0;
            grp_cnt  <= '0;
            busy     <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          if (!hold) begin
            tw_valid  <= 1'b1;
            stage_idx <= stg_cnt;
            grp_idx   <= grp_cnt;
            Mul_sel   <= mul_sel_of(stg_cnt, mode_lat);
            grp_cnt   <= grp_cnt + GRP_W'(1);
            if (last_grp) begin
              stg_cnt <= stg_cnt + 2'd1;
              if (stg_cnt == LAST_STG) begin
                state <= DONE;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dtfag_seq_ctrl.md
DTFAG_SEQ_CTRL -- requirements
Module: dtfag_seq_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter STG_NUM, default 4: number of radix-16 stages per transform (65536-point).
REQ-003 Parameter GRP_W, default 12: group-counter width; groups per stage = 2^GRP_W = 4096.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port rst  input  1  synchronous active-high reset.
REQ-006 Port start  input  1  single-cycle transform request, sampled only in IDLE.
REQ-007 Port ifft_mode  input  1  0 = FFT, 1 = IFFT; latched on accepted start.
REQ-008 Port hold  input  1  downstream stall; 1 = issue no group this cycle.
REQ-009 Port Mul_sel  output  2  multiplier-input select for the DTFAG mux.
REQ-010 Port stage_idx  output  2  stage of the issued group.
REQ-011 Port grp_idx  output  GRP_W  group index of the issued group.
REQ-012 Port tw_valid  output  1  stage_idx/grp_idx/Mul_sel describe a valid group.
REQ-013 Port busy  output  1  transform in progress.
REQ-014 Port done  output  1  single-cycle completion pulse.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 IDLE -> RUN on start=1: latch ifft_mode, clear stage and group counters.
REQ-017 In RUN with hold=0, one group SHALL issue per cycle; counters advance on the same edge.
REQ-018 Group counter SHALL increment and wrap 4095 -> 0; on wrap the stage counter SHALL increment.
REQ-019 Issuing stage 3, group 4095 SHALL move RUN -> DONE; DONE -> IDLE unconditionally after one cycle.
REQ-020 In RUN with hold=1, counters and state SHALL freeze, and tw_valid SHALL be 0 on the next cycle.
REQ-021 All outputs SHALL be registered; an issue decided in cycle t appears on the outputs in cycle t+1.
REQ-022 Latency: start sampled at edge t -> RUN at t+1 -> first tw_valid=1 in the cycle after edge t+2 (hold=0).
REQ-023 Mul_sel SHALL be 2'd1 for issued groups in stages 0-2.
REQ-024 Mul_sel SHALL be 2'd0 for stage 3 when FFT, and 2'd2 (N^-1 scaling) for stage 3 when IFFT.
REQ-025 When tw_valid=0, Mul_sel SHALL be 2'd0; stage_idx and grp_idx SHALL hold their last values.
REQ-026 busy SHALL be 1 from the cycle after start acceptance through the done cycle inclusive.
REQ-027 done SHALL be 1 for exactly one cycle, the cycle immediately after the final tw_valid.
REQ-028 start while busy=1 SHALL be ignored, with no restart and no re-latch of ifft_mode.
REQ-029 ifft_mode changes while busy SHALL have no effect on the current transform.
REQ-030 A transform with hold=0 throughout SHALL issue exactly 16384 groups, in order stage-major, group ascending.
REQ-031 hold=1 in IDLE or DONE SHALL have no effect.

Reset
REQ-032 On rst=1 at a clock edge, the block SHALL enter IDLE and set Mul_sel=0, stage_idx=0, grp_idx=0, tw_valid=0, busy=0, done=0, and latched mode=FFT.
REQ-033 Reset SHALL override start and hold in the same cycle; mid-transform reset SHALL abort with no done pulse.

Verification
REQ-034 FFT run, hold=0: start at cycle 0 -> tw_valid first high at cycle 2 with (0,0); 16384 consecutive valids; stage-3 Mul_sel=0; done at cycle 16386.
REQ-035 IFFT run: stage 0 group 0 -> Mul_sel=1; stage 3 group 0 -> Mul_sel=2; done once.
REQ-036 Stall: hold=1 for 5 cycles after group (1,100) issues -> 5 tw_valid=0 cycles; next valid is (1,101); done delayed by 5.
REQ-037 Wrap: after (0,4095) the next valid is (1,0); after (3,4095) tw_valid=0 and done=1 the following cycle.
REQ-038 Ignored inputs: start and ifft_mode toggled at group (2,7) -> sequence and Mul_sel unchanged.
REQ-039 Reset at group (1,2000) -> next cycle all outputs 0, busy=0, no done; a new start runs a full 16384-group transform.
